// File: rtl/pipe_regs_pkg.sv
// Shared constants for the pipeline register chain: forward-select codes and the nop encoding.
package pipe_regs_pkg;

    localparam logic [1:0] FW_GRF = 2'd0;
    localparam logic [1:0] FW_W   = 2'd1;
    localparam logic [1:0] FW_M   = 2'd2;
    localparam logic [1:0] FW_E   = 2'd3;

    localparam logic [31:0] NOP_IR = 32'h0000_0000;

endpackage

// File: rtl/pipe_regs_stage_reg.sv
// One pipeline field: synchronous active-low reset, then clear, then enable.
module stage_reg #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_regs.sv
// F/D, D/E, E/M, M/W pipeline registers with stall/bubble handling, operand forwarding muxes
// and a saturating stall-cycle counter.
module pipe_regs
    import pipe_regs_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Stall,
    input  logic [1:0]       FW_D_rs,
    input  logic [1:0]       FW_D_rt,
    input  logic [1:0]       FW_E_rs,
    input  logic [1:0]       FW_E_rt,
    input  logic             FW_M_rt,
    input  logic [WIDTH-1:0] F_IR,
    input  logic [WIDTH-1:0] F_PC,
    input  logic [WIDTH-1:0] D_RD1,
    input  logic [WIDTH-1:0] D_RD2,
    input  logic [WIDTH-1:0] D_EXT,
    input  logic [WIDTH-1:0] E_fwd,
    input  logic [WIDTH-1:0] M_fwd,
    input  logic [WIDTH-1:0] W_fwd,
    input  logic [WIDTH-1:0] E_ALU,
    input  logic [WIDTH-1:0] M_DM,
    output logic             PC_en,
    output logic [WIDTH-1:0] D_IR,
    output logic [WIDTH-1:0] D_PC,
    output logic [WIDTH-1:0] D_rs_val,
    output logic [WIDTH-1:0] D_rt_val,
    output logic [WIDTH-1:0] E_IR,
    output logic [WIDTH-1:0] E_PC,
    output logic [WIDTH-1:0] E_EXT,
    output logic [WIDTH-1:0] E_rs_val,
    output logic [WIDTH-1:0] E_rt_val,
    output logic [WIDTH-1:0] M_IR,
    output logic [WIDTH-1:0] M_PC,
    output logic [WIDTH-1:0] M_ALU,
    output logic [WIDTH-1:0] M_rt_val,
    output logic [WIDTH-1:0] W_IR,
    output logic [WIDTH-1:0] W_PC,
    output logic [WIDTH-1:0] W_ALU,
    output logic [WIDTH-1:0] W_DM,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             fd_en;
    logic [WIDTH-1:0] e_rs_lat;
    logic [WIDTH-1:0] e_rt_lat;
    logic [WIDTH-1:0] m_rt_lat;
    logic [CNT_W-1:0] stall_cnt_q;

    assign fd_en = ~Stall;
    assign PC_en = ~Stall;

    // F/D: frozen while stalled so the held instruction re-evaluates its operands
    stage_reg #(.WIDTH(WIDTH)) u_fd_ir (
        .clk(clk), .reset(reset), .en(fd_en), .clr(1'b0), .d(F_IR), .q(D_IR)
    );
    stage_reg #(.WIDTH(WIDTH)) u_fd_pc (
        .clk(clk), .reset(reset), .en(fd_en), .clr(1'b0), .d(F_PC), .q(D_PC)
    );

    always_comb begin
        unique case (FW_D_rs)
            FW_GRF:  D_rs_val = D_RD1;
            FW_W:    D_rs_val = W_fwd;
            FW_M:    D_rs_val = M_fwd;
            default: D_rs_val = E_fwd;
        endcase
    end

    always_comb begin
        unique case (FW_D_rt)
            FW_GRF:  D_rt_val = D_RD2;
            FW_W:    D_rt_val = W_fwd;
            FW_M:    D_rt_val = M_fwd;
            default: D_rt_val = E_fwd;
        endcase
    end

    // D/E: stall turns these fields into a nop bubble
    stage_reg #(.WIDTH(WIDTH)) u_de_ir (
        .clk(clk), .reset(reset), .en(1'b1), .clr(Stall), .d(D_IR), .q(E_IR)
    );
    stage_reg #(.WIDTH(WIDTH)) u_de_ext (
        .clk(clk), .reset(reset), .en(1'b1), .clr(Stall), .d(D_EXT), .q(E_EXT)
    );
    stage_reg #(.WIDTH(WIDTH)) u_de_rs (
        .clk(clk), .reset(reset), .en(1'b1), .clr(Stall), .d(D_rs_val), .q(e_rs_lat)
    );
    stage_reg #(.WIDTH(WIDTH)) u_de_rt (
        .clk(clk), .reset(reset), .en(1'b1), .clr(Stall), .d(D_rt_val), .q(e_rt_lat)
    );
    // PC is not cleared so the bubble still shows where it came from
    stage_reg #(.WIDTH(WIDTH)) u_de_pc (
        .clk(clk), .reset(reset), .en(1'b1), .clr(1'b0), .d(D_PC), .q(E_PC)
    );

    always_comb begin
        unique case (FW_E_rs)
            FW_M:    E_rs_val = M_fwd;
            FW_W:    E_rs_val = W_fwd;
            default: E_rs_val = e_rs_lat;
        endcase
    end

    always_comb begin
        unique case (FW_E_rt)
            FW_M:    E_rt_val = M_fwd;
            FW_W:    E_rt_val = W_fwd;
            default: E_rt_val = e_rt_lat;
        endcase
    end

    // E/M and M/W always advance
    stage_reg #(.WIDTH(WIDTH)) u_em_ir (
        .clk(clk), .reset(reset), .en(1'b1), .clr(1'b0), .d(E_IR), .q(M_IR)
    );
    stage_reg #(.WIDTH(WIDTH)) u_em_pc (
        .clk(clk), .reset(reset), .en(1'b1), .clr(1'b0), .d(E_PC), .q(M_PC)
    );
    stage_reg #(.WIDTH(WIDTH)) u_em_alu (
        .clk(clk), .reset(reset), .en(1'b1), .clr(1'b0), .d(E_ALU), .q(M_ALU)
    );
    stage_reg #(.WIDTH(WIDTH)) u_em_rt (
        .clk(clk), .reset(reset), .en(1'b1), .clr(1'b0), .d(E_rt_val), .q(m_rt_lat)
    );

    assign M_rt_val = FW_M_rt ? W_fwd : m_rt_lat;

    stage_reg #(.WIDTH(WIDTH)) u_mw_ir (
        .clk(clk), .reset(reset), .en(1'b1), .clr(1'b0), .d(M_IR), .q(W_IR)
    );
    stage_reg #(.WIDTH(WIDTH)) u_mw_pc (
        .clk(clk), .reset(reset), .en(1'b1), .clr(1'b0), .d(M_PC), .q(W_PC)
    );
    stage_reg #(.WIDTH(WIDTH)) u_mw_alu (
        .clk(clk), .reset(reset), .en(1'b1), .clr(1'b0), .d(M_ALU), .q(W_ALU)
    );
    stage_reg #(.WIDTH(WIDTH)) u_mw_dm (
        .clk(clk), .reset(reset), .en(1'b1), .clr(1'b0), .d(M_DM), .q(W_DM)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else if (Stall && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_regs.sv
// Self-checking bench for pipe_regs: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural pipeline model.
module tb_pipe_regs;

    logic        clk = 1'b0;
    logic        reset;
    logic        Stall;
    logic [1:0]  FW_D_rs, FW_D_rt, FW_E_rs, FW_E_rt;
    logic        FW_M_rt;
    logic [31:0] F_IR, F_PC, D_RD1, D_RD2, D_EXT, E_fwd, M_fwd, W_fwd, E_ALU, M_DM;

    logic        PC_en;
    logic [31:0] D_IR, D_PC, D_rs_val, D_rt_val, E_IR, E_PC, E_EXT, E_rs_val, E_rt_val;
    logic [31:0] M_IR, M_PC, M_ALU, M_rt_val, W_IR, W_PC, W_ALU, W_DM;
    logic [15:0] stall_cnt;

    logic        s_PC_en;
    logic [31:0] s_D_IR, s_D_PC, s_D_rs_val, s_D_rt_val, s_E_IR, s_E_PC, s_E_EXT;
    logic [31:0] s_E_rs_val, s_E_rt_val, s_M_IR, s_M_PC, s_M_ALU, s_M_rt_val;
    logic [31:0] s_W_IR, s_W_PC, s_W_ALU, s_W_DM;
    logic [1:0]  s_stall_cnt;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    pipe_regs #(.WIDTH(32), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .Stall(Stall),
        .FW_D_rs(FW_D_rs), .FW_D_rt(FW_D_rt), .FW_E_rs(FW_E_rs), .FW_E_rt(FW_E_rt),
        .FW_M_rt(FW_M_rt), .F_IR(F_IR), .F_PC(F_PC), .D_RD1(D_RD1), .D_RD2(D_RD2),
        .D_EXT(D_EXT), .E_fwd(E_fwd), .M_fwd(M_fwd), .W_fwd(W_fwd), .E_ALU(E_ALU),
        .M_DM(M_DM), .PC_en(PC_en), .D_IR(D_IR), .D_PC(D_PC), .D_rs_val(D_rs_val),
        .D_rt_val(D_rt_val), .E_IR(E_IR), .E_PC(E_PC), .E_EXT(E_EXT), .E_rs_val(E_rs_val),
        .E_rt_val(E_rt_val), .M_IR(M_IR), .M_PC(M_PC), .M_ALU(M_ALU), .M_rt_val(M_rt_val),
        .W_IR(W_IR), .W_PC(W_PC), .W_ALU(W_ALU), .W_DM(W_DM), .stall_cnt(stall_cnt)
    );

    // Narrow counter instance to reach saturation quickly
    pipe_regs #(.WIDTH(32), .CNT_W(2)) dut_small (
        .clk(clk), .reset(reset), .Stall(Stall),
        .FW_D_rs(FW_D_rs), .FW_D_rt(FW_D_rt), .FW_E_rs(FW_E_rs), .FW_E_rt(FW_E_rt),
        .FW_M_rt(FW_M_rt), .F_IR(F_IR), .F_PC(F_PC), .D_RD1(D_RD1), .D_RD2(D_RD2),
        .D_EXT(D_EXT), .E_fwd(E_fwd), .M_fwd(M_fwd), .W_fwd(W_fwd), .E_ALU(E_ALU),
        .M_DM(M_DM), .PC_en(s_PC_en), .D_IR(s_D_IR), .D_PC(s_D_PC), .D_rs_val(s_D_rs_val),
        .D_rt_val(s_D_rt_val), .E_IR(s_E_IR), .E_PC(s_E_PC), .E_EXT(s_E_EXT),
        .E_rs_val(s_E_rs_val), .E_rt_val(s_E_rt_val), .M_IR(s_M_IR), .M_PC(s_M_PC),
        .M_ALU(s_M_ALU), .M_rt_val(s_M_rt_val), .W_IR(s_W_IR), .W_PC(s_W_PC),
        .W_ALU(s_W_ALU), .W_DM(s_W_DM), .stall_cnt(s_stall_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: index 1=D, 2=E, 3=M, 4=W
    logic [31:0] mir [1:4];
    logic [31:0] mpc [1:4];
    logic [31:0] m_ext, m_ers, m_ert, m_alu3, m_mrt, m_alu4, m_dm4;
    int unsigned m_cnt, m_cnt2;

    function automatic logic [31:0] d_pick(input logic [1:0] c, input logic [31:0] grf);
        logic [31:0] src [4];
        src[0] = grf; src[1] = W_fwd; src[2] = M_fwd; src[3] = E_fwd;
        return src[c];
    endfunction

    function automatic logic [31:0] e_pick(input logic [1:0] c, input logic [31:0] lat);
        if (c == 2'd2) return M_fwd;
        if (c == 2'd1) return W_fwd;
        return lat;
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 1; i <= 4; i++) begin
                mir[i] = 32'h0;
                mpc[i] = 32'h0;
            end
            m_ext = 0; m_ers = 0; m_ert = 0; m_alu3 = 0; m_mrt = 0; m_alu4 = 0; m_dm4 = 0;
            m_cnt = 0; m_cnt2 = 0;
        end else begin
            // update from the back so each stage reads its predecessor's old value
            mir[4] = mir[3]; mpc[4] = mpc[3]; m_alu4 = m_alu3; m_dm4 = M_DM;
            mir[3] = mir[2]; mpc[3] = mpc[2]; m_alu3 = E_ALU; m_mrt = e_pick(FW_E_rt, m_ert);
            if (Stall) begin
                mir[2] = 32'h0; m_ext = 0; m_ers = 0; m_ert = 0;
            end else begin
                mir[2] = mir[1]; m_ext = D_EXT;
                m_ers = d_pick(FW_D_rs, D_RD1); m_ert = d_pick(FW_D_rt, D_RD2);
            end
            mpc[2] = mpc[1];
            if (!Stall) begin
                mir[1] = F_IR; mpc[1] = F_PC;
            end else begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt2 < 3) m_cnt2++;
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            check("PC_en", {31'b0, PC_en}, {31'b0, ~Stall});
            check("D_IR", D_IR, mir[1]);
            check("D_PC", D_PC, mpc[1]);
            check("D_rs_val", D_rs_val, d_pick(FW_D_rs, D_RD1));
            check("D_rt_val", D_rt_val, d_pick(FW_D_rt, D_RD2));
            check("E_IR", E_IR, mir[2]);
            check("E_PC", E_PC, mpc[2]);
            check("E_EXT", E_EXT, m_ext);
            check("E_rs_val", E_rs_val, e_pick(FW_E_rs, m_ers));
            check("E_rt_val", E_rt_val, e_pick(FW_E_rt, m_ert));
            check("M_IR", M_IR, mir[3]);
            check("M_PC", M_PC, mpc[3]);
            check("M_ALU", M_ALU, m_alu3);
            check("M_rt_val", M_rt_val, FW_M_rt ? W_fwd : m_mrt);
            check("W_IR", W_IR, mir[4]);
            check("W_PC", W_PC, mpc[4]);
            check("W_ALU", W_ALU, m_alu4);
            check("W_DM", W_DM, m_dm4);
            check("stall_cnt", {16'h0, stall_cnt}, m_cnt);
            check("stall_cnt_small", {30'h0, s_stall_cnt}, m_cnt2);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] d_exp [4];

    initial begin
        reset = 1'b0; Stall = 1'b0;
        FW_D_rs = 0; FW_D_rt = 0; FW_E_rs = 0; FW_E_rt = 0; FW_M_rt = 0;
        F_IR = 32'h3c010001; F_PC = 32'h3000;
        D_RD1 = 0; D_RD2 = 0; D_EXT = 32'h7; E_fwd = 0; M_fwd = 0; W_fwd = 0;
        E_ALU = 32'h99; M_DM = 32'h77;

        // Reset held for two edges
        tick(); tick();
        check_en = 1'b1;
        check("rst_D_IR", D_IR, 32'h0);
        check("rst_E_PC", E_PC, 32'h0);
        check("rst_W_DM", W_DM, 32'h0);
        check("rst_cnt", {16'h0, stall_cnt}, 32'h0);

        reset = 1'b1;
        tick();
        check("rel_D_IR", D_IR, 32'h3c010001);
        check("rel_D_PC", D_PC, 32'h3000);

        // Single stall with beq in D
        F_IR = 32'h10220003; F_PC = 32'h3004;
        tick();
        F_IR = 32'hdeadbeef; F_PC = 32'h3008;
        Stall = 1'b1;
        #1 check("stall_PC_en", {31'b0, PC_en}, 32'h0);
        tick();
        check("stall_D_IR", D_IR, 32'h10220003);
        check("stall_E_IR", E_IR, 32'h0);
        check("stall_E_PC", E_PC, 32'h3004);
        check("stall_M_IR", M_IR, 32'h3c010001);
        check("stall_cnt1", {16'h0, stall_cnt}, 32'h1);
        Stall = 1'b0;
        tick();
        check("unstall_D_IR", D_IR, 32'hdeadbeef);
        check("unstall_E_IR", E_IR, 32'h10220003);

        // D forwarding, same-cycle visibility
        D_RD1 = 32'h11; W_fwd = 32'h22; M_fwd = 32'h33; E_fwd = 32'h44;
        d_exp[0] = 32'h11; d_exp[1] = 32'h22; d_exp[2] = 32'h33; d_exp[3] = 32'h44;
        for (int c = 0; c < 4; c++) begin
            FW_D_rs = 2'(c);
            #1 check("dfwd_rs", D_rs_val, d_exp[c]);
        end
        FW_D_rs = 0;

        // E and M forwarding
        D_RD2 = 32'h5; FW_D_rt = 0;
        tick();
        M_fwd = 32'hA; W_fwd = 32'hB;
        FW_E_rt = 2'd2; #1 check("efwd_2", E_rt_val, 32'hA);
        FW_E_rt = 2'd1; #1 check("efwd_1", E_rt_val, 32'hB);
        FW_E_rt = 2'd0; #1 check("efwd_0", E_rt_val, 32'h5);
        FW_E_rt = 2'd3; #1 check("efwd_3", E_rt_val, 32'h5);
        FW_E_rt = 2'd0;
        tick();
        FW_M_rt = 1'b1; #1 check("mfwd_1", M_rt_val, 32'hB);
        FW_M_rt = 1'b0; #1 check("mfwd_0", M_rt_val, 32'h5);
        tick();

        // Three-cycle stall: bubbles show up in W consecutively
        Stall = 1'b1;
        tick(); check("ms_W1", W_IR, 32'hdeadbeef);
        tick(); check("ms_W2", W_IR, 32'hdeadbeef);
        tick(); check("ms_W3", W_IR, 32'h0);
        Stall = 1'b0;
        tick(); check("ms_W4", W_IR, 32'h0);
        tick(); check("ms_W5", W_IR, 32'h0);
        tick(); check("ms_W6", W_IR, 32'hdeadbeef);
        check("ms_cnt", {16'h0, stall_cnt}, 32'd4);
        check("ms_cnt_small", {30'h0, s_stall_cnt}, 32'd3);

        // Reset wins over stall, then saturate the narrow counter
        Stall = 1'b1; reset = 1'b0;
        tick();
        check("rs_cnt", {16'h0, stall_cnt}, 32'h0);
        check("rs_D_IR", D_IR, 32'h0);
        check("rs_E_PC", E_PC, 32'h0);
        reset = 1'b1;
        repeat (5) tick();
        check("sat_cnt_small", {30'h0, s_stall_cnt}, 32'd3);
        check("sat_cnt", {16'h0, stall_cnt}, 32'd5);
        Stall = 1'b0;

        // Random traffic
        for (int n = 0; n < 2000; n++) begin
            reset   = ($urandom_range(0, 99) != 0);
            Stall   = ($urandom_range(0, 3) == 0);
            FW_D_rs = 2'($urandom); FW_D_rt = 2'($urandom);
            FW_E_rs = 2'($urandom); FW_E_rt = 2'($urandom);
            FW_M_rt = 1'($urandom);
            F_IR = $urandom; F_PC = $urandom; D_RD1 = $urandom; D_RD2 = $urandom;
            D_EXT = $urandom; E_fwd = $urandom; M_fwd = $urandom; W_fwd = $urandom;
            E_ALU = $urandom; M_DM = $urandom;
            tick();
        end

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_regs.md
Name: pipe_regs

Overview:
- Pipeline-register chain (F/D, D/E, E/M, M/W) for the 5-stage MIPS core.
- Sits on the consumer side of the hazard unit. It obeys the hazard unit's Stall, and applies its forward-select codes (FW_D_rs/rt, FW_E_rs/rt, FW_M_rt) to the operand buses.
- It holds F/D on stall and injects a nop bubble into D/E.
- It keeps a saturating stall-cycle counter for performance debug.

Parameters:
- WIDTH, 32, datapath/IR/PC width.
- CNT_W, 16, stall-counter width.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- Stall  in  1  from hazard unit; freeze F/D and PC, bubble D/E.
- FW_D_rs, FW_D_rt  in  2 each  0=GRF read, 1=W value, 2=M value, 3=E value.
- FW_E_rs, FW_E_rt  in  2 each  0=D/E-latched value, 1=W value, 2=M value.
- FW_M_rt  in  1  0=E/M-latched rt, 1=W value.
- F_IR, F_PC  in  WIDTH  fetched instruction and PC.
- D_RD1, D_RD2  in  WIDTH  GRF read data.
- D_EXT  in  WIDTH  extended immediate.
- E_fwd, M_fwd, W_fwd  in  WIDTH  forwardable result of each stage (supplied by datapath).
- E_ALU  in  WIDTH  ALU result.
- M_DM  in  WIDTH  data-memory read data.
- PC_en  out  1  = ~Stall.
- D_IR, D_PC  out  WIDTH  F/D register.
- D_rs_val, D_rt_val  out  WIDTH  forwarded D operands (combinational), for branch compare and jr.
- E_IR, E_PC, E_EXT  out  WIDTH  D/E register.
- E_rs_val, E_rt_val  out  WIDTH  forwarded E operands (combinational).
- M_IR, M_PC, M_ALU  out  WIDTH  E/M register.
- M_rt_val  out  WIDTH  forwarded M store data (combinational).
- W_IR, W_PC, W_ALU, W_DM  out  WIDTH  M/W register.
- stall_cnt  out  CNT_W  saturating count of stalled cycles.

Behaviour:
- Reset (reset==0 at edge): every register and stall_cnt go to 0. Reset takes priority over Stall. Mid-operation reset flushes all stages to nop (IR=0 is sll $0, a harmless nop).
- F/D:
  - Stall=0: D_IR<=F_IR, D_PC<=F_PC.
  - Stall=1: hold.
- D operand muxes (combinational): D_rs_val = sel(FW_D_rs; D_RD1, W_fwd, M_fwd, E_fwd). D_rt_val is the same using D_RD2.
- D/E:
  - Stall=0: E_IR<=D_IR, E_PC<=D_PC, E_EXT<=D_EXT; latched rs/rt <= D_rs_val/D_rt_val.
  - Stall=1: E_IR, E_EXT and latched rs/rt <= 0 (bubble). E_PC<=D_PC, so the bubble carries the PC for debug.
- E operand muxes: E_rs_val = FW_E_rs==2 ? M_fwd : ==1 ? W_fwd : latched rs. Code 3 is treated as 0. E_rt_val is the same using the rt codes.
- E/M always advances (ignores Stall): M_IR<=E_IR, M_PC<=E_PC, M_ALU<=E_ALU; latched rt <= E_rt_val.
- M_rt_val = FW_M_rt ? W_fwd : latched rt.
- M/W always advances: W_IR<=M_IR, W_PC<=M_PC, W_ALU<=M_ALU, W_DM<=M_DM.
- Latency: an instruction reaches W exactly 3 edges after entering D/E.
- Stall is a level signal. N consecutive stall cycles insert N bubbles while D holds the same instruction.
- stall_cnt:
  - increments on every edge with Stall=1 and reset=1.
  - saturates at 2^CNT_W-1 (no wrap).
- All forward muxes are purely combinational: zero added latency. The selected value must be visible in the same cycle the code is presented.
- Simultaneous Stall and valid forward code in D: the mux output still reflects the code. The held instruction re-evaluates each cycle.

Decomposition:
- Shared head package (existing define header): FW code constants FW_GRF=0, FW_W=1, FW_M=2, FW_E=3, and NOP_IR=32'h0.
- One natural sub-module: stage_reg, a WIDTH-wide register with synchronous active-low reset, enable and clear. Instantiate it per field; the D/E fields use clear=Stall, and the F/D fields use en=~Stall.

Test Plan:
- Reset: hold reset=0 for 2 cycles with F_IR=0x3c010001 -> all IR/PC/data outputs 0, stall_cnt=0. Release -> D_IR=0x3c010001 after 1 edge.
- Single stall: Stall=1 for 1 cycle with D_IR=0x10220003 (beq) -> D_IR held, E_IR=0 next edge, M_IR gets the prior E_IR, stall_cnt=1, PC_en=0 during the stall.
- D forwarding: D_RD1=0x11, W_fwd=0x22, M_fwd=0x33, E_fwd=0x44 -> D_rs_val for FW_D_rs=0..3 is 0x11, 0x22, 0x33, 0x44 in the same cycle.
- E and M forwarding: latched rt=0x5, M_fwd=0xA, W_fwd=0xB -> E_rt_val=0xA (code 2), 0xB (code 1), 0x5 (code 0). FW_M_rt=1 -> M_rt_val=0xB.
- Multi-stall and saturation:
  - Stall held 3 cycles -> 3 bubbles appear consecutively in W_IR 3 edges later.
  - With CNT_W=2, Stall held 5 cycles -> stall_cnt stops at 3.
- Reset during stall: Stall=1 and reset=0 on the same edge -> all zero, stall_cnt=0 (no increment).
